// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared phase/state encodings for the traffic light controller
// Purpose : phase codes shared with the countdown timer, controller FSM state
//           enum, default timer width and small decode helpers.
// Ports   : none (package).
package traffic_pkg;

    localparam int TIMER_W_DEF = 32;

    // Phase codes as seen by the timer; 2'b11 is never produced.
    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } phase_e;

    typedef enum logic [1:0] {
        S_INIT,
        S_LOAD,
        S_RUN,
        S_NIGHT
    } state_e;

    function automatic phase_e next_phase(input phase_e p);
        case (p)
            GREEN:   return YELLOW;
            YELLOW:  return RED;
            default: return GREEN;
        endcase
    endfunction

    // Lamp decode packed as {red, yellow, green}.
    function automatic logic [2:0] lamp_decode(input phase_e p);
        case (p)
            GREEN:   return 3'b001;
            YELLOW:  return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/traffic_blink_gen.sv
// rtl/traffic_blink_gen.sv - night-mode blink tick generator
// Purpose : counts BLINK_TICKS enabled cycles and pulses toggle_o on the last
//           one; the count is held at zero while disabled so every night
//           period starts with a full half-period.
// Ports   : clk, rst_n (async active-low), en_i (count enable),
//           toggle_o (one-cycle pulse: flip the blinking lamp on this edge).
module traffic_blink_gen #(
    parameter int BLINK_TICKS = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic toggle_o
);

    localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;

    assign toggle_o = en_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// rtl/traffic_light_ctrl.sv - GREEN/YELLOW/RED phase sequencer with night flashing mode
// Purpose : drives the countdown timer (current_state, load) and the lamps;
//           advances one phase each time the timer reports 0. Night mode is
//           only entered at RED expiry and flashes yellow until night drops.
// Config  : define TRAFFIC_PED_REQUEST_EN to add the pedestrian request
//           feature (ped_req input, ped_walk output, PED_MIN_TICKS parameter).
// Ports   : clk, rst_n (async active-low), timer (remaining count),
//           night (night-mode level request), load (one-cycle timer load),
//           current_state (phase code to timer), lamp_g/lamp_y/lamp_r,
//           [ped_req (request pulse), ped_walk (walk signal)].
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter int TIMER_W     = TIMER_W_DEF,
    parameter int BLINK_TICKS = 5
`ifdef TRAFFIC_PED_REQUEST_EN
    ,parameter int PED_MIN_TICKS = 5
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TIMER_W-1:0] timer,
    input  logic               night,
`ifdef TRAFFIC_PED_REQUEST_EN
    input  logic               ped_req,
    output logic               ped_walk,
`endif
    output logic               load,
    output logic [1:0]         current_state,
    output logic               lamp_g,
    output logic               lamp_y,
    output logic               lamp_r
);

    state_e state_q;
    phase_e phase_q;
    logic   load_q;
    logic   lamp_g_q;
    logic   lamp_y_q;
    logic   lamp_r_q;
    logic   blink_toggle;
    logic   ped_cut;
    logic   expire;

`ifdef TRAFFIC_PED_REQUEST_EN
    logic ped_pend_q;
    logic ped_walk_q;

    // A pending request cuts GREEN short only while enough time remains.
    assign ped_cut = ped_pend_q && (phase_q == GREEN) &&
                     (timer > TIMER_W'(PED_MIN_TICKS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ped_pend_q <= 1'b0;
            ped_walk_q <= 1'b0;
        end else begin
            if (expire) begin
                ped_walk_q <= (phase_q == YELLOW);
            end
            // Entering RED serves the request; that wins over a new pulse.
            if (expire && phase_q == YELLOW) begin
                ped_pend_q <= 1'b0;
            end else if (ped_req && state_q != S_NIGHT && phase_q != RED) begin
                ped_pend_q <= 1'b1;
            end
        end
    end

    assign ped_walk = ped_walk_q;
`else
    assign ped_cut = 1'b0;
`endif

    // Timer expiry and a pedestrian cut in the same cycle give one advance.
    assign expire = (state_q == S_RUN) && ((timer == '0) || ped_cut);

    traffic_blink_gen #(
        .BLINK_TICKS(BLINK_TICKS)
    ) u_blink (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (state_q == S_NIGHT),
        .toggle_o(blink_toggle)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q                          <= S_INIT;
            phase_q                          <= RED;
            load_q                           <= 1'b0;
            {lamp_r_q, lamp_y_q, lamp_g_q}   <= 3'b100;
        end else begin
            case (state_q)
                S_INIT: begin
                    state_q                        <= S_LOAD;
                    phase_q                        <= GREEN;
                    load_q                         <= 1'b1;
                    {lamp_r_q, lamp_y_q, lamp_g_q} <= lamp_decode(GREEN);
                end
                S_LOAD: begin
                    // The timer captures its duration on this edge.
                    state_q <= S_RUN;
                    load_q  <= 1'b0;
                end
                S_RUN: begin
                    if (expire) begin
                        if (phase_q == RED && night) begin
                            state_q                        <= S_NIGHT;
                            phase_q                        <= YELLOW;
                            {lamp_r_q, lamp_y_q, lamp_g_q} <= 3'b010;
                        end else begin
                            state_q                        <= S_LOAD;
                            phase_q                        <= next_phase(phase_q);
                            load_q                         <= 1'b1;
                            {lamp_r_q, lamp_y_q, lamp_g_q} <= lamp_decode(next_phase(phase_q));
                        end
                    end
                end
                S_NIGHT: begin
                    if (!night) begin
                        state_q                        <= S_LOAD;
                        phase_q                        <= GREEN;
                        load_q                         <= 1'b1;
                        {lamp_r_q, lamp_y_q, lamp_g_q} <= lamp_decode(GREEN);
                    end else if (blink_toggle) begin
                        lamp_y_q <= ~lamp_y_q;
                    end
                end
            endcase
        end
    end

    assign load          = load_q;
    assign current_state = phase_q;
    assign lamp_g        = lamp_g_q;
    assign lamp_y        = lamp_y_q;
    assign lamp_r        = lamp_r_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// tb/tb_traffic_light_ctrl.sv - randomized self-checking bench for traffic_light_ctrl
module tb_traffic_light_ctrl;

    localparam int GREEN_T = 15;
    localparam int YELLOW_T = 3;
    localparam int RED_T = 18;
    localparam int BLINK = 5;
    localparam int PED_MIN = 5;
    localparam int NCYC = 4000;
`ifdef TRAFFIC_PED_REQUEST_EN
    localparam bit PED_EN = 1'b1;
`else
    localparam bit PED_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] timer;
    logic        night = 1'b0;
    logic        load;
    logic [1:0]  cs;
    logic        lamp_g;
    logic        lamp_y;
    logic        lamp_r;
    logic        ped_req = 1'b0;
`ifdef TRAFFIC_PED_REQUEST_EN
    logic        ped_walk;
`endif

    always #50 clk = ~clk;

    traffic_light_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .timer        (timer),
        .night        (night),
`ifdef TRAFFIC_PED_REQUEST_EN
        .ped_req      (ped_req),
        .ped_walk     (ped_walk),
`endif
        .load         (load),
        .current_state(cs),
        .lamp_g       (lamp_g),
        .lamp_y       (lamp_y),
        .lamp_r       (lamp_r)
    );

    function automatic int dur(input int p);
        case (p)
            0:       return GREEN_T;
            1:       return YELLOW_T;
            2:       return RED_T;
            default: return 0;
        endcase
    endfunction

    // Countdown timer (ONE_SECOND=1), closed around the DUT.
    logic [31:0] tmr_q;
    bit          zero_force = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)            tmr_q <= 32'd0;
        else if (load)         tmr_q <= 32'(dur(int'(cs)));
        else if (tmr_q != 0)   tmr_q <= tmr_q - 32'd1;
    end

    // Occasional forced zero models zero-length phases.
    assign timer = zero_force ? 32'd0 : tmr_q;

    int passed = 0;
    int total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model: phase 0/1/2 = G/Y/R, plus flags for the just-reset
    // cycle, the load cycle and night mode; blink derived from night age.
    int m_phase;
    bit m_load;
    bit m_fresh;
    bit m_night;
    int m_age;
    bit m_pend;

    task automatic model_reset();
        m_phase = 2;
        m_load  = 1'b0;
        m_fresh = 1'b1;
        m_night = 1'b0;
        m_age   = 0;
        m_pend  = 1'b0;
    endtask

    task automatic model_edge(input bit nt, input logic [31:0] t, input bit pr);
        bit run;
        bit fire;
        int old_ph;
        old_ph = m_phase;
        run  = !m_fresh && !m_load && !m_night;
        fire = run && (t == 0 || (PED_EN && m_phase == 0 && m_pend && t > PED_MIN));
        if (fire && old_ph == 1)                       m_pend = 1'b0;
        else if (pr && !m_night && old_ph != 2)        m_pend = 1'b1;
        if (m_fresh) begin
            m_fresh = 1'b0;
            m_phase = 0;
            m_load  = 1'b1;
        end else if (m_load) begin
            m_load = 1'b0;
        end else if (m_night) begin
            if (!nt) begin
                m_night = 1'b0;
                m_phase = 0;
                m_load  = 1'b1;
            end else begin
                m_age++;
            end
        end else if (fire) begin
            if (m_phase == 2 && nt) begin
                m_night = 1'b1;
                m_age   = 0;
                m_phase = 1;
            end else begin
                m_phase = (m_phase + 1) % 3;
                m_load  = 1'b1;
            end
        end
    endtask

    task automatic compare();
        bit eg, ey, er;
        if (m_night) begin
            eg = 1'b0;
            er = 1'b0;
            ey = ((m_age / BLINK) % 2) == 0;
        end else begin
            eg = (m_phase == 0);
            ey = (m_phase == 1);
            er = (m_phase == 2);
        end
        check("load", 32'(load), 32'(m_load));
        check("current_state", 32'(cs), 32'(m_phase));
        check("lamp_g", 32'(lamp_g), 32'(eg));
        check("lamp_y", 32'(lamp_y), 32'(ey));
        check("lamp_r", 32'(lamp_r), 32'(er));
        check("lamps_onehot", 32'($countones({lamp_g, lamp_y, lamp_r}) <= 1), 32'd1);
        check("state_not_11", 32'(cs != 2'b11), 32'd1);
`ifdef TRAFFIC_PED_REQUEST_EN
        check("ped_walk", 32'(ped_walk), 32'(m_phase == 2 && !m_night && !m_fresh));
`endif
    endtask

    bit          ns;
    bit          ps;
    bit          rs;
    logic [31:0] ts;
    bit          ld_prev;
    int          ph_prev;

    initial begin
        model_reset();
        ld_prev = 1'b0;
        ph_prev = 0;
        repeat (2) @(negedge clk);
        compare();
        rst_n = 1'b1;
        rs = 1'b1;
        ns = night;
        ps = 1'b0;
        ts = timer;
        for (int i = 0; i < NCYC; i++) begin
            @(posedge clk);
            if (rs) model_edge(ns, ts, ps);
            @(negedge clk);
            compare();
            // Timer must hold the new phase's duration one edge after load.
            if (ld_prev) check("timer_reload", tmr_q, 32'(dur(ph_prev)));
            ld_prev = m_load;
            ph_prev = m_phase;

            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                #1;
                model_reset();
                compare();
                ld_prev = 1'b0;
            end
            if ($urandom_range(0, 39) == 0) night = ~night;
            zero_force = ($urandom_range(0, 29) == 0);
`ifdef TRAFFIC_PED_REQUEST_EN
            ped_req = ($urandom_range(0, 14) == 0);
`endif
            rs = rst_n;
            ns = night;
            ps = ped_req;
            ts = zero_force ? 32'd0 : tmr_q;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
